// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: edge/level capture, masking, highest-index-wins
// arbitration and a registered valid/ready ID presentation to one consumer.
module irq_priority_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [NUM_IRQ-1:0] irq_edge,
  input  logic               irq_ready,
  input  logic [NUM_IRQ-1:0] ovf_clr,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overflow,
  output logic               dbg_state_o
);

  // Handshake: irq_id/irq_valid are held stable while irq_valid=1 and irq_ready=0;
  // the transfer happens on the rising edge where both are high, and irq_ready
  // is ignored while irq_valid=0.
  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] prev_q, pend_q, pend_d, ovf_q, ovf_d;
  logic [NUM_IRQ-1:0] rise, clr, elig;
  logic [ID_W-1:0]    id_q, id_d, win_id;
  logic               accept, any_elig;

  assign rise     = irq_in & ~prev_q;
  assign accept   = (state_q == ST_PRESENT) && irq_ready;
  assign elig     = pend_q & irq_mask;
  assign any_elig = |elig;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = accept && (id_q == ID_W'(i + 1));
    end
  end

  // Edge channels: a new rising edge beats the acceptance clear; a rising edge
  // on a still-pending (and not just accepted) channel is a lost interrupt.
  assign pend_d = (irq_edge & (rise | (pend_q & ~clr))) | (~irq_edge & irq_in);
  assign ovf_d  = (irq_edge & rise & pend_q & ~clr) | (ovf_q & ~ovf_clr);

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i]) win_id = ID_W'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d = ST_PRESENT;
          id_d    = win_id;
        end else begin
          id_d = '0;
        end
      end
      ST_PRESENT: begin
        if (irq_ready) begin
          state_d = ST_IDLE;
          id_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      prev_q  <= irq_in;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign irq_valid   = (state_q == ST_PRESENT);
  assign irq_id      = id_q;
  assign pending     = pend_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed vector table, hand sequences for reset
// and the single-channel variant, then randomized traffic against a reference model.
module tb_irq_priority_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0, irq_mask = '1, irq_edge = '1, ovf_clr = '0;
  logic         irq_ready = 1'b0;
  logic         irq_valid, dbg_state;
  logic [3:0]   irq_id;
  logic [N-1:0] pending, overflow;

  logic in1 = 1'b0, mask1 = 1'b1, edge1 = 1'b1, rdy1 = 1'b0, clr1 = 1'b0;
  logic valid1, id1, pend1, ovf1, dbg1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];

  // reference model state
  bit [N-1:0] m_prev, m_pend, m_ovf;
  bit         m_valid;
  int         m_id;

  typedef struct {
    logic [7:0] in, mask, edg, clr;
    logic       ready;
    logic       ev;
    logic [3:0] eid;
    logic [7:0] epend, eovf;
  } vec_t;
  vec_t tbl[$];

  irq_priority_ctrl #(.NUM_IRQ(N), .ID_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask),
    .irq_edge(irq_edge), .irq_ready(irq_ready), .ovf_clr(ovf_clr),
    .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending),
    .overflow(overflow), .dbg_state_o(dbg_state)
  );

  irq_priority_ctrl #(.NUM_IRQ(1), .ID_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .irq_in(in1), .irq_mask(mask1),
    .irq_edge(edge1), .irq_ready(rdy1), .ovf_clr(clr1),
    .irq_valid(valid1), .irq_id(id1), .pending(pend1),
    .overflow(ovf1), .dbg_state_o(dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_pend  = '0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_id    = 0;
    exp_q.delete();
  endtask

  // One clock of the rules: capture, arbitration on the old pending set, handshake.
  task automatic model_next();
    int         win;
    bit         acc, rose, taken;
    bit [N-1:0] np, no;
    acc = m_valid && irq_ready;
    if (acc) exp_q.push_back(8'(m_id));
    win = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i] && irq_mask[i]) begin
        win = i;
        break;
      end
    end
    for (int i = 0; i < N; i++) begin
      rose  = irq_in[i] && !m_prev[i];
      taken = acc && (m_id == i + 1);
      if (irq_edge[i]) np[i] = rose ? 1'b1 : (taken ? 1'b0 : m_pend[i]);
      else             np[i] = irq_in[i];
      if (irq_edge[i] && rose && m_pend[i] && !taken) no[i] = 1'b1;
      else if (ovf_clr[i])                            no[i] = 1'b0;
      else                                            no[i] = m_ovf[i];
    end
    if (m_valid) begin
      if (irq_ready) begin
        m_valid = 1'b0;
        m_id    = 0;
      end
    end else if (win >= 0) begin
      m_valid = 1'b1;
      m_id    = win + 1;
    end
    m_pend = np;
    m_ovf  = no;
    m_prev = irq_in;
  endtask

  // driver step: advance model, score accepted IDs, clock, compare outputs
  task automatic step();
    logic [7:0] got;
    model_next();
    if (irq_valid && irq_ready) begin
      got = 8'(irq_id);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_accept: got id %0d accepted, expected no accept", got);
      end else begin
        check("sb_accept_id", 32'(got), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    check("model_valid", 32'(irq_valid), 32'(m_valid));
    check("model_id", 32'(irq_id), 32'(m_id));
    check("model_pending", 32'(pending), 32'(m_pend));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic add_vec(input logic [7:0] in, input logic [7:0] mask, input logic [7:0] edg,
                         input logic [7:0] clr, input logic ready, input logic ev,
                         input logic [3:0] eid, input logic [7:0] epend, input logic [7:0] eovf);
    vec_t v;
    v.in = in; v.mask = mask; v.edg = edg; v.clr = clr; v.ready = ready;
    v.ev = ev; v.eid = eid; v.epend = epend; v.eovf = eovf;
    tbl.push_back(v);
  endtask

  initial begin
    // two simultaneous edge pulses, ready held: ID 5 then ID 3
    add_vec(8'h14, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h14, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 1, 5, 8'h14, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 1, 3, 8'h04, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // ID 3 held while a higher channel arrives, then ID 8
    add_vec(8'h04, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'h04, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 0, 1, 3, 8'h04, 8'h00);
    add_vec(8'h80, 8'hFF, 8'hFF, 8'h00, 0, 1, 3, 8'h84, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 0, 1, 3, 8'h84, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h80, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 1, 8, 8'h80, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // double pulse on ch4: one delivery, sticky overflow, then cleared
    add_vec(8'h10, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'h10, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 0, 1, 5, 8'h10, 8'h00);
    add_vec(8'h10, 8'hFF, 8'hFF, 8'h00, 0, 1, 5, 8'h10, 8'h10);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h10);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h10);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h10, 1, 0, 0, 8'h00, 8'h00);
    // ch6 masked: ID 2 first, ID 7 after unmask
    add_vec(8'h42, 8'hBF, 8'hFF, 8'h00, 0, 0, 0, 8'h42, 8'h00);
    add_vec(8'h00, 8'hBF, 8'hFF, 8'h00, 0, 1, 2, 8'h42, 8'h00);
    add_vec(8'h00, 8'hBF, 8'hFF, 8'h00, 1, 0, 0, 8'h40, 8'h00);
    add_vec(8'h00, 8'hBF, 8'hFF, 8'h00, 1, 0, 0, 8'h40, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 1, 7, 8'h40, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // level ch0 held: ID 1 every 2 cycles, nothing after deassert
    add_vec(8'h01, 8'hFF, 8'hFE, 8'h00, 1, 0, 0, 8'h01, 8'h00);
    add_vec(8'h01, 8'hFF, 8'hFE, 8'h00, 1, 1, 1, 8'h01, 8'h00);
    add_vec(8'h01, 8'hFF, 8'hFE, 8'h00, 1, 0, 0, 8'h01, 8'h00);
    add_vec(8'h01, 8'hFF, 8'hFE, 8'h00, 1, 1, 1, 8'h01, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFE, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    add_vec(8'h00, 8'hFF, 8'hFE, 8'h00, 1, 0, 0, 8'h00, 8'h00);

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_valid", 32'(irq_valid), 0);
    check("reset_id", 32'(irq_id), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_state", 32'(dbg_state), 0);

    for (int k = 0; k < tbl.size(); k++) begin
      irq_in    = tbl[k].in;
      irq_mask  = tbl[k].mask;
      irq_edge  = tbl[k].edg;
      ovf_clr   = tbl[k].clr;
      irq_ready = tbl[k].ready;
      step();
      check($sformatf("vec%0d_valid", k), 32'(irq_valid), 32'(tbl[k].ev));
      check($sformatf("vec%0d_id", k), 32'(irq_id), 32'(tbl[k].eid));
      check($sformatf("vec%0d_pending", k), 32'(pending), 32'(tbl[k].epend));
      check($sformatf("vec%0d_overflow", k), 32'(overflow), 32'(tbl[k].eovf));
    end

    // async reset while presenting ID 4 with overflow set
    irq_edge = '1; irq_mask = '1; ovf_clr = '0; irq_ready = 1'b0;
    irq_in = 8'h08; step();
    irq_in = 8'h00; step();
    irq_in = 8'h08; step();
    irq_in = 8'h00; step();
    check("prerst_valid", 32'(irq_valid), 1);
    check("prerst_id", 32'(irq_id), 4);
    check("prerst_overflow", 32'(overflow), 32'h08);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(irq_valid), 0);
    check("async_rst_id", 32'(irq_id), 0);
    check("async_rst_pending", 32'(pending), 0);
    check("async_rst_overflow", 32'(overflow), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("postrst_no_valid", 32'(irq_valid), 0);
    end

    // single-channel instance
    in1 = 1'b1; step();
    check("n1_pend", 32'(pend1), 1);
    check("n1_valid_early", 32'(valid1), 0);
    in1 = 1'b0; step();
    check("n1_valid", 32'(valid1), 1);
    check("n1_id", 32'(id1), 1);
    rdy1 = 1'b1; step();
    check("n1_acc_valid", 32'(valid1), 0);
    check("n1_acc_id", 32'(id1), 0);
    check("n1_acc_pend", 32'(pend1), 0);
    step();
    check("n1_idle_valid", 32'(valid1), 0);
    rdy1 = 1'b0;

    // randomized traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) irq_edge = 8'($urandom);
      irq_in    = 8'($urandom) & 8'($urandom);
      irq_mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      irq_ready = 1'($urandom_range(0, 1));
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      step();
    end

    check("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
